// File: rtl/mont_red_pkg.sv
// Shared types and width helpers for the Montgomery reduction sequencer.
// Optional final subtraction is selected with MONT_RED_FINAL_SUB_EN.
package mont_red_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    SUB  = 2'd2,
    DONE = 2'd3
  } state_e;

  // Default geometry: 43-bit reduction words, two words per modulus.
  localparam int DEF_W  = 43;
  localparam int DEF_NW = 2;
  localparam int DEF_N  = DEF_W * DEF_NW;
  localparam int DEF_TW = 2 * DEF_N + 2;

  // Modulus width N = W*NW.
  function automatic int calc_n(input int w, input int nw);
    return w * nw;
  endfunction

  // Working width of T: 2N+2 holds the carry-save sum and every REDC partial sum.
  function automatic int calc_tw(input int w, input int nw);
    return 2 * w * nw + 2;
  endfunction

  // Step counter width; it must count up to NW without wrapping.
  function automatic int cnt_width(input int nw);
    return (nw > 0) ? $clog2(nw + 1) : 1;
  endfunction

endpackage

// File: rtl/mont_red_seq_if.sv
// Request/response bundle of the Montgomery reduction sequencer.
// master = requester/consumer side, slave = sequencer side.
interface mont_red_seq_if #(
  parameter int W  = 43,
  parameter int NW = 2
);
  import mont_red_pkg::*;

  localparam int N = calc_n(W, NW);

  logic             in_valid;
  logic             in_ready;
  logic [2*N-1:0]   a_c;
  logic [2*N-1:0]   a_s;
  logic [N-1:0]     p;
  logic [W-1:0]     p_prime;
  logic             out_valid;
  logic             out_ready;
  logic [N:0]       r;
  logic             busy;

  modport master (
    output in_valid, a_c, a_s, p, p_prime, out_ready,
    input  in_ready, out_valid, r, busy
  );

  modport slave (
    input  in_valid, a_c, a_s, p, p_prime, out_ready,
    output in_ready, out_valid, r, busy
  );

endinterface

// File: rtl/mont_red_step.sv
// One radix-2^W REDC step: T' = (T + m*p) >> W with m = T*p_prime mod 2^W.
// Purely combinational; the sequencer reuses a single instance for every word.
module mont_red_step
  import mont_red_pkg::*;
#(
  parameter int W  = 43,
  parameter int NW = 2,
  localparam int N  = calc_n(W, NW),
  localparam int TW = calc_tw(W, NW)
) (
  input  logic [TW-1:0] t_i,
  input  logic [N-1:0]  p_i,
  input  logic [W-1:0]  p_prime_i,
  output logic [TW-1:0] t_o
);

  logic [W-1:0]   m;
  logic [W+N-1:0] mp;
  logic [TW-1:0]  sum;

  // Quotient digit, product with the modulus, and the exact shift by one word
  // (the low W bits of sum are zero because m cancels them).
  always_comb begin
    m   = W'(t_i[W-1:0] * p_prime_i);
    mp  = m * p_i;
    sum = t_i + TW'(mp);
    t_o = sum >> W;
  end

endmodule

// File: rtl/mont_red_seq.sv
// Word-serial Montgomery reduction sequencer: resolves a carry-save pair to T
// and returns T * 2^(-W*NW) mod p (< 2p, or < p with MONT_RED_FINAL_SUB_EN).
module mont_red_seq
  import mont_red_pkg::*;
#(
  parameter int W  = 43,
  parameter int NW = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  mont_red_seq_if.slave  bus
);

  localparam int N  = calc_n(W, NW);
  localparam int TW = calc_tw(W, NW);
  localparam int CW = cnt_width(NW);
  localparam logic [CW-1:0] LAST_STEP = CW'(NW - 1);

  state_e          state_q, state_d;
  logic [TW-1:0]   t_q, t_d;
  logic [N-1:0]    p_q, p_d;
  logic [W-1:0]    pp_q, pp_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [N:0]      r_q, r_d;
  logic [TW-1:0]   step_t;

  mont_red_step #(
    .W  (W),
    .NW (NW)
  ) u_step (
    .t_i       (t_q),
    .p_i       (p_q),
    .p_prime_i (pp_q),
    .t_o       (step_t)
  );

  // State and datapath registers; reset aborts any transaction in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      t_q     <= '0;
      p_q     <= '0;
      pp_q    <= '0;
      cnt_q   <= '0;
      r_q     <= '0;
    end else begin
      state_q <= state_d;
      t_q     <= t_d;
      p_q     <= p_d;
      pp_q    <= pp_d;
      cnt_q   <= cnt_d;
      r_q     <= r_d;
    end
  end

  // Next-state and datapath update for load, iterate, optional subtract, hold.
  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    p_d     = p_q;
    pp_d    = pp_q;
    cnt_d   = cnt_q;
    r_d     = r_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          // Carry-save resolution at full width so no carry is lost.
          t_d     = TW'(bus.a_c) + TW'(bus.a_s);
          p_d     = bus.p;
          pp_d    = bus.p_prime;
          cnt_d   = '0;
          state_d = ITER;
        end
      end
      ITER: begin
        t_d   = step_t;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST_STEP) begin
`ifdef MONT_RED_FINAL_SUB_EN
          state_d = SUB;
`else
          r_d     = step_t[N:0];
          state_d = DONE;
`endif
        end
      end
`ifdef MONT_RED_FINAL_SUB_EN
      SUB: begin
        if (t_q >= TW'(p_q)) begin
          r_d = (N+1)'(t_q - TW'(p_q));
        end else begin
          r_d = t_q[N:0];
        end
        state_d = DONE;
      end
`endif
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.busy      = (state_q != IDLE);
  assign bus.r         = r_q;

endmodule

// File: tb/tb_mont_red_seq.sv
// Directed bench for mont_red_seq at W=8, NW=2, p=0xFFF1, p_prime=0xEF.
// Expected values follow MONT_RED_FINAL_SUB_EN when it is defined.
module tb_mont_red_seq;

  localparam int W  = 8;
  localparam int NW = 2;
  localparam logic [15:0] P   = 16'hFFF1;
  localparam logic [7:0]  PP  = 8'hEF;
  // 2^-16 mod 0xFFF1: 2^16 = 15 (mod p), 15*4368 = p-1, so inverse = p-4368.
  localparam longint INV16 = 61153;
`ifdef MONT_RED_FINAL_SUB_EN
  localparam bit SUB_EN = 1'b1;
`else
  localparam bit SUB_EN = 1'b0;
`endif
  localparam int EXP_LAT = SUB_EN ? NW + 1 : NW;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mont_red_seq_if #(.W(W), .NW(NW)) bus();

  mont_red_seq #(.W(W), .NW(NW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issue one request and wait (bounded) for out_valid; returns latency in edges.
  task automatic start_req(input logic [31:0] ac, input logic [31:0] as,
                           output int lat, output bit ir_low, output bit timeout);
    @(negedge clk);
    bus.in_valid  = 1'b1;
    bus.a_c       = ac;
    bus.a_s       = as;
    bus.p         = P;
    bus.p_prime   = PP;
    bus.out_ready = 1'b0;
    @(posedge clk);
    #1;
    // Scramble request inputs: the DUT must use only what it latched.
    bus.in_valid = 1'b0;
    bus.a_c      = $urandom;
    bus.a_s      = $urandom;
    bus.p        = 16'h1234;
    bus.p_prime  = 8'h00;
    lat     = 0;
    ir_low  = 1'b1;
    timeout = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (bus.in_ready !== 1'b0) ir_low = 1'b0;
      if (bus.out_valid === 1'b1) begin
        timeout = 1'b0;
        break;
      end
      lat++;
    end
  endtask

  // Complete the output handshake, optionally with a randomly stalling consumer.
  task automatic end_req(input bit rnd);
    bit rdy;
    rdy = 1'b0;
    for (int k = 0; k < 32 && !rdy; k++) begin
      rdy = (!rnd || k == 31) ? 1'b1 : 1'($urandom_range(1, 0));
      bus.out_ready = rdy;
      @(negedge clk);
    end
    bus.out_ready = 1'b0;
  endtask

  task automatic run_vec(input string tag, input logic [31:0] ac, input logic [31:0] as,
                         input logic [16:0] exp_r);
    int lat;
    bit ir_low;
    bit tmo;
    start_req(ac, as, lat, ir_low, tmo);
    chk({tag, "_timeout"}, 64'(tmo), 64'd0);
    chk({tag, "_lat"}, 64'(lat), 64'(EXP_LAT));
    chk({tag, "_in_ready_low"}, 64'(ir_low), 64'd1);
    chk({tag, "_r"}, 64'(bus.r), 64'(exp_r));
    $display("vec %s a_c=%h a_s=%h r=%h lat=%0d", tag, ac, as, bus.r, lat);
    end_req(1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] t;
    logic [31:0] ac;
    longint      x;
    longint      res;
    longint      exp_v;
    int          lat;
    bit          ir_low;
    bit          tmo;

    bus.in_valid  = 1'b0;
    bus.a_c       = '0;
    bus.a_s       = '0;
    bus.p         = '0;
    bus.p_prime   = '0;
    bus.out_ready = 1'b0;

    // Reset values
    @(negedge clk);
    chk("rst_in_ready",  64'(bus.in_ready),  64'd1);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_busy",      64'(bus.busy),      64'd0);
    chk("rst_r",         64'(bus.r),         64'd0);
    #2 rst_n = 1'b1;

    // Directed vectors
    run_vec("t_2pow16",   32'h0001_0000, 32'h0000_0000, 17'h00001);
    run_vec("carry_save", 32'h0000_8000, 32'h0000_8000, 17'h00001);
    run_vec("t_p_2pow16", 32'hFFF1_0000, 32'h0000_0000, SUB_EN ? 17'h00000 : 17'h0FFF1);

    // Random T < p*2^16 against T*2^-16 mod p, with a stalling consumer
    for (int i = 0; i < 1000; i++) begin
      t  = $urandom_range(32'hFFF0_FFFF, 0);
      ac = $urandom_range(t, 0);
      start_req(ac, t - ac, lat, ir_low, tmo);
      chk("rand_timeout", 64'(tmo), 64'd0);
      chk("rand_lat", 64'(lat), 64'(EXP_LAT));
      x     = ((longint'(t) % longint'(P)) * INV16) % longint'(P);
      res   = longint'(bus.r);
      exp_v = (!SUB_EN && res == x + longint'(P)) ? x + longint'(P) : x;
      chk("rand_r", 64'(res), 64'(exp_v));
      if (i % 100 == 0) $display("rand %0d T=%h r=%h exp=%h", i, t, res, exp_v);
      end_req(1'b1);
    end

    // Consumer stall in DONE
    start_req(32'h0001_0000, 32'h0, lat, ir_low, tmo);
    chk("stall_timeout", 64'(tmo), 64'd0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("stall_out_valid", 64'(bus.out_valid), 64'd1);
      chk("stall_r",         64'(bus.r),         64'd1);
      chk("stall_in_ready",  64'(bus.in_ready),  64'd0);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk("release_in_ready",  64'(bus.in_ready),  64'd1);
    chk("release_out_valid", 64'(bus.out_valid), 64'd0);
    chk("release_busy",      64'(bus.busy),      64'd0);
    $display("stall test r=%h released", bus.r);

    // Abort with reset in the second ITER step
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.a_c      = 32'h0000_8000;
    bus.a_s      = 32'h0000_8000;
    bus.p        = P;
    bus.p_prime  = PP;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("abort_busy_before", 64'(bus.busy), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("abort_in_ready",  64'(bus.in_ready),  64'd1);
    chk("abort_out_valid", 64'(bus.out_valid), 64'd0);
    chk("abort_busy",      64'(bus.busy),      64'd0);
    chk("abort_r",         64'(bus.r),         64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("abort_no_output", 64'(bus.out_valid), 64'd0);
    end
    $display("abort test done");
    run_vec("after_abort_zero", 32'h0, 32'h0, 17'h00000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
